spi_channel_router: RTL and testbench
=====================================

# spi_channel_router

Parametrised router for the shared user-area SPI bus. It synchronises the pad-side SPI clock, PICO and N active-low chip selects into `sys_clock_i`. It grants the bus to exactly one enabled channel at a time and fans the synchronised bus out to the on-chip SPI peripherals. It muxes the granted channel's POCI back to the pad with a proper output enable, and detects and counts chip-select conflicts. It replaces the hard-wired shared SCK/PICO/POCI nets between the peripherals and the pads.

## Interface
Parameters:
- `N_CH`, 4, number of SPI peripheral channels (2..16)
- `SYNC_STAGES`, 2, synchroniser depth for pad inputs (>=2)
- `ERR_W`, 8, width of saturating conflict counter (>=1)

Ports:
- `sys_clock_i` in 1: system clock; the only clock in the block
- `rst_ni` in 1: reset, asynchronous, active-low
- `spi_clock_i` in 1: pad SCK, asynchronous to `sys_clock_i`
- `spi_pico_i` in 1: pad PICO
- `spi_cs_ni` in N_CH: pad chip selects, active-low, one per channel
- `spi_poci_o` out 1: pad POCI
- `spi_poci_oeb_o` out 1: pad output enable for POCI, active-low
- `ch_enable_i` in N_CH: per-channel enable; a disabled channel's CS is ignored
- `ch_spi_clock_o` out 1: synchronised, aligned SCK to all channels
- `ch_spi_pico_o` out 1: synchronised, aligned PICO to all channels
- `ch_spi_cs_no` out N_CH: gated chip selects; at most one bit low
- `ch_spi_poci_i` in N_CH: POCI from each channel
- `active_ch_o` out $clog2(N_CH): index of the granted channel
- `busy_o` out 1: high while a channel holds the grant
- `conflict_o` out 1: sticky conflict flag
- `conflict_count_o` out ERR_W: saturating conflict-event count
- `clear_i` in 1: synchronous clear of `conflict_o` and `conflict_count_o`

## Operation
- Synchronisers: `spi_clock_i`, `spi_pico_i` and each `spi_cs_ni` bit each pass through SYNC_STAGES flops.
  - CS flops reset to 1; SCK and PICO flops reset to 0.
- Alignment stage: the synchronised SCK and PICO get one extra register stage, so they stay aligned with the registered `ch_spi_cs_no`.
- Request vector: `req = ~cs_sync & ch_enable_i`.
- FSM states are IDLE, ACTIVE, CONFLICT and DRAIN:
  - IDLE, req == 0: stay in IDLE.
  - IDLE, exactly one req bit set: go to ACTIVE. Latch `active_ch_o` to that index; drive that `ch_spi_cs_no` bit low.
  - IDLE, two or more req bits set: go to CONFLICT. No grant; set `conflict_o`; increment the counter once.
  - ACTIVE, granted req bit drops (CS high, or enable removed): release CS.
    - CS high: go to IDLE.
    - Enable removed while pad CS is still low: go to DRAIN.
  - ACTIVE, another req bit rises: keep the grant (lock). Set `conflict_o` and increment the counter once per rising req edge.
  - CONFLICT: stay until req == 0, then go to IDLE.
  - DRAIN: stay until the granted pad CS (synchronised) is high, then go to IDLE. All `ch_spi_cs_no` stay high throughout DRAIN.
- POCI return path:
  - In ACTIVE only: `spi_poci_o = ch_spi_poci_i[active_ch_o]` (combinational mux) and `spi_poci_oeb_o = 0`.
  - All other states: `spi_poci_o = 0` and `spi_poci_oeb_o = 1`.
- `busy_o` is high exactly in ACTIVE.
- `active_ch_o` holds its last value outside ACTIVE.
- Counter: saturates at 2^ERR_W-1 and never wraps.
- `clear_i` zeroes the flag and the counter on the next edge.
  - If a conflict event occurs in the same cycle as `clear_i`, the event wins: count = 1 and flag = 1.

## Timing
- Reset values:
  - `ch_spi_cs_no` all 1s; `ch_spi_clock_o` 0; `ch_spi_pico_o` 0.
  - `spi_poci_o` 0; `spi_poci_oeb_o` 1; `busy_o` 0; `active_ch_o` 0.
  - `conflict_o` 0; `conflict_count_o` 0; FSM in IDLE.
- Grant latency: a pad CS falling edge sampled at edge 0 gives `ch_spi_cs_no` low after edge SYNC_STAGES+1.
- Release latency: `ch_spi_cs_no` goes high after edge SYNC_STAGES+1 following the pad CS rising edge.
- SCK/PICO latency: SYNC_STAGES+1 cycles, identical to CS, so the channel sees the same relative ordering as the pad.
- POCI path: zero cycles through the block, pad → channel → pad. The channel's own output register sets its timing.
- Pad SCK must be ≤ sys_clock_i/4 for the synchroniser to capture every edge.
- Reset mid-transfer: all CS are released immediately (asynchronous) and POCI is tri-stated. After reset, a still-low pad CS is treated as a new request from IDLE.

## Test plan
- N_CH=4, SYNC_STAGES=2; all enabled; drop `spi_cs_ni[2]` → `ch_spi_cs_no`=4'b1011 and `busy_o`=1 exactly 3 cycles later. `active_ch_o`=2. SCK/PICO patterns reappear on `ch_*` 3 cycles delayed.
- During the ch2 grant, drive `ch_spi_poci_i[2]` toggling → `spi_poci_o` follows the same cycle with `spi_poci_oeb_o`=0. Raise CS → oeb=1 and poci=0 once `busy_o` falls.
- Drop CS0 and CS1 on the same cycle from IDLE → no `ch_spi_cs_no` bit low, `conflict_o`=1, count=1. Raise both → IDLE; then CS3 alone is granted.
- ch1 active; drop CS3 twice in separate pulses → ch1 grant kept, count=2. Pulse `clear_i` → count=0 and flag=0.
- ch1 active; deassert `ch_enable_i[1]` with pad CS low → CS released next cycle; new CS0 requests are ignored until pad CS1 rises (DRAIN), then CS0 is granted.
- ERR_W=2; generate 5 conflicts → count saturates at 3. Assert `rst_ni` low mid-transfer → all outputs at reset values asynchronously.

Source files
------------

// File: rtl/spi_channel_router.sv
// Shared SPI bus router: synchronises pad SCK/PICO/CS into sys_clock_i, grants one
// enabled channel at a time, muxes POCI back to the pad and counts CS conflicts.
module spi_channel_router #(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int ERR_W       = 8
) (
    input  logic                    sys_clock_i,
    input  logic                    rst_ni,
    input  logic                    spi_clock_i,
    input  logic                    spi_pico_i,
    input  logic [N_CH-1:0]         spi_cs_ni,
    output logic                    spi_poci_o,
    output logic                    spi_poci_oeb_o,
    input  logic [N_CH-1:0]         ch_enable_i,
    output logic                    ch_spi_clock_o,
    output logic                    ch_spi_pico_o,
    output logic [N_CH-1:0]         ch_spi_cs_no,
    input  logic [N_CH-1:0]         ch_spi_poci_i,
    output logic [$clog2(N_CH)-1:0] active_ch_o,
    output logic                    busy_o,
    output logic                    conflict_o,
    output logic [ERR_W-1:0]        conflict_count_o,
    input  logic                    clear_i
);
    localparam int IDX_W = $clog2(N_CH);

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_CONFLICT, S_DRAIN} state_t;

    state_t                          r_state;
    state_t                          w_state_next;
    logic [SYNC_STAGES-1:0]          r_sck_sync;
    logic [SYNC_STAGES-1:0]          r_pico_sync;
    logic [SYNC_STAGES-1:0][N_CH-1:0] r_cs_sync;
    logic                            r_sck_align;
    logic                            r_pico_align;
    logic [N_CH-1:0]                 r_cs_out;
    logic [N_CH-1:0]                 r_req_prev;
    logic [IDX_W-1:0]                r_active;
    logic                            r_conflict;
    logic [ERR_W-1:0]                r_count;

    logic [N_CH-1:0]                 w_cs_sync;
    logic [N_CH-1:0]                 w_req;
    logic [N_CH-1:0]                 w_rise;
    logic [N_CH-1:0]                 w_active_mask;
    logic [N_CH-1:0]                 w_next_mask;
    logic [IDX_W-1:0]                w_req_idx;
    logic [IDX_W-1:0]                w_grant_idx;
    logic                            w_req_one;
    logic                            w_load;
    logic                            w_event;
    logic                            w_busy;

    always_ff @(posedge sys_clock_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sck_sync   <= '0;
            r_pico_sync  <= '0;
            r_cs_sync    <= '1;
            r_sck_align  <= 1'b0;
            r_pico_align <= 1'b0;
        end else begin
            r_sck_sync   <= {r_sck_sync[SYNC_STAGES-2:0], spi_clock_i};
            r_pico_sync  <= {r_pico_sync[SYNC_STAGES-2:0], spi_pico_i};
            r_cs_sync    <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_ni};
            // Extra stage keeps SCK/PICO in step with the registered CS outputs.
            r_sck_align  <= r_sck_sync[SYNC_STAGES-1];
            r_pico_align <= r_pico_sync[SYNC_STAGES-1];
        end
    end

    assign w_cs_sync = r_cs_sync[SYNC_STAGES-1];
    assign w_req     = ~w_cs_sync & ch_enable_i;
    assign w_req_one = (w_req != '0) && ((w_req & (w_req - N_CH'(1))) == '0);
    assign w_rise    = w_req & ~r_req_prev & ~w_active_mask;

    always_comb begin
        w_req_idx = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (w_req[i]) w_req_idx = IDX_W'(i);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_mask
            assign w_active_mask[gi] = (r_active == IDX_W'(gi));
            assign w_next_mask[gi]   = (w_grant_idx == IDX_W'(gi));
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_event      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req_one) begin
                    w_state_next = S_ACTIVE;
                    w_load       = 1'b1;
                end else if (w_req != '0) begin
                    w_state_next = S_CONFLICT;
                    w_event      = 1'b1;
                end
            end
            S_ACTIVE: begin
                // Losing the request with pad CS still low means the enable was pulled.
                if (!w_req[r_active]) begin
                    w_state_next = w_cs_sync[r_active] ? S_IDLE : S_DRAIN;
                end else if (w_rise != '0) begin
                    w_event = 1'b1;
                end
            end
            S_CONFLICT: begin
                if (w_req == '0) w_state_next = S_IDLE;
            end
            S_DRAIN: begin
                if (w_cs_sync[r_active]) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign w_grant_idx = w_load ? w_req_idx : r_active;

    always_ff @(posedge sys_clock_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= S_IDLE;
            r_active   <= '0;
            r_cs_out   <= '1;
            r_req_prev <= '0;
            r_conflict <= 1'b0;
            r_count    <= '0;
        end else begin
            r_state    <= w_state_next;
            r_req_prev <= w_req;
            if (w_load) r_active <= w_req_idx;
            r_cs_out   <= (w_state_next == S_ACTIVE) ? ~w_next_mask : '1;
            // A conflict in the same cycle as clear_i wins and restarts the count at one.
            if (w_event) begin
                r_conflict <= 1'b1;
                if (clear_i)        r_count <= ERR_W'(1);
                else if (~&r_count) r_count <= r_count + ERR_W'(1);
            end else if (clear_i) begin
                r_conflict <= 1'b0;
                r_count    <= '0;
            end
        end
    end

    assign w_busy           = (r_state == S_ACTIVE);
    assign busy_o           = w_busy;
    assign active_ch_o      = r_active;
    assign ch_spi_cs_no     = r_cs_out;
    assign ch_spi_clock_o   = r_sck_align;
    assign ch_spi_pico_o    = r_pico_align;
    assign spi_poci_o       = w_busy ? ch_spi_poci_i[r_active] : 1'b0;
    assign spi_poci_oeb_o   = ~w_busy;
    assign conflict_o       = r_conflict;
    assign conflict_count_o = r_count;

endmodule

// File: tb/tb_spi_channel_router.sv
// Bench for spi_channel_router (N_CH=4, SYNC_STAGES=2, ERR_W=2): vector table,
// directed latency/clear/saturation/reset sequences, then random traffic vs a model.
module tb_spi_channel_router;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       sck, pico, clr;
    logic [3:0] cs, en, poci;
    logic       poci_o, poci_oeb, ch_sck, ch_pico, busy, conf;
    logic [3:0] ch_cs;
    logic [1:0] act, cnt;

    int n_vec = 0;
    int n_err = 0;

    spi_channel_router #(.N_CH(4), .SYNC_STAGES(2), .ERR_W(2)) dut (
        .sys_clock_i      (clk),
        .rst_ni           (rst_n),
        .spi_clock_i      (sck),
        .spi_pico_i       (pico),
        .spi_cs_ni        (cs),
        .spi_poci_o       (poci_o),
        .spi_poci_oeb_o   (poci_oeb),
        .ch_enable_i      (en),
        .ch_spi_clock_o   (ch_sck),
        .ch_spi_pico_o    (ch_pico),
        .ch_spi_cs_no     (ch_cs),
        .ch_spi_poci_i    (poci),
        .active_ch_o      (act),
        .busy_o           (busy),
        .conflict_o       (conf),
        .conflict_count_o (cnt),
        .clear_i          (clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] cs;
        logic [3:0] en;
        logic       clr;
        logic [3:0] poci;
        logic [3:0] e_cs;
        logic       e_busy;
        logic [1:0] e_act;
        logic       e_conf;
        logic [1:0] e_cnt;
        logic       e_poci;
        logic       e_oeb;
    } vec_t;

    vec_t tbl[19];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] c, input logic [3:0] e, input logic cl, input logic [3:0] p);
        cs = c; en = e; clr = cl; poci = p;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference model: pad history queues plus a few ownership flags.
    logic [3:0] m_q_cs[$];
    logic       m_q_sck[$];
    logic       m_q_pico[$];
    int         m_owner, m_cnt;
    bit         m_busy, m_drain, m_wait, m_conf;
    logic [3:0] m_prev;

    task automatic model_reset();
        m_q_cs = '{4'hF, 4'hF};
        m_q_sck = '{1'b0, 1'b0, 1'b0};
        m_q_pico = '{1'b0, 1'b0, 1'b0};
        m_owner = 0; m_cnt = 0;
        m_busy = 0; m_drain = 0; m_wait = 0; m_conf = 0;
        m_prev = 4'h0;
    endtask

    task automatic model_step();
        logic [3:0] sync;
        logic [3:0] req;
        bit ev;
        sync = m_q_cs[0];
        req  = ~sync & en;
        ev   = 0;
        if (m_busy) begin
            if (!req[m_owner]) begin
                m_busy  = 0;
                m_drain = !sync[m_owner];
            end else if ((req & ~m_prev & ~(4'b1 << m_owner)) != 4'h0) begin
                ev = 1;
            end
        end else if (m_drain) begin
            if (sync[m_owner]) m_drain = 0;
        end else if (m_wait) begin
            if (req == 4'h0) m_wait = 0;
        end else if ($countones(req) == 1) begin
            m_busy = 1;
            for (int i = 0; i < 4; i++) if (req[i]) m_owner = i;
        end else if (req != 4'h0) begin
            m_wait = 1;
            ev = 1;
        end
        if (ev) begin
            m_conf = 1;
            m_cnt  = clr ? 1 : ((m_cnt < 3) ? m_cnt + 1 : 3);
        end else if (clr) begin
            m_conf = 0;
            m_cnt  = 0;
        end
        m_prev = req;
        void'(m_q_cs.pop_front());   m_q_cs.push_back(cs);
        void'(m_q_sck.pop_front());  m_q_sck.push_back(sck);
        void'(m_q_pico.pop_front()); m_q_pico.push_back(pico);
    endtask

    initial begin
        logic [13:0] exp_v, got_v;
        logic [3:0]  r_cs, r_en;

        tbl[0]  = '{4'hF, 4'hF, 1'b0, 4'h0, 4'hF, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1};
        tbl[1]  = '{4'hB, 4'hF, 1'b0, 4'h4, 4'hB, 1'b1, 2'd2, 1'b0, 2'd0, 1'b1, 1'b0};
        tbl[2]  = '{4'hB, 4'hF, 1'b0, 4'hB, 4'hB, 1'b1, 2'd2, 1'b0, 2'd0, 1'b0, 1'b0};
        tbl[3]  = '{4'hF, 4'hF, 1'b0, 4'hF, 4'hF, 1'b0, 2'd2, 1'b0, 2'd0, 1'b0, 1'b1};
        tbl[4]  = '{4'hC, 4'hF, 1'b0, 4'hF, 4'hF, 1'b0, 2'd2, 1'b1, 2'd1, 1'b0, 1'b1};
        tbl[5]  = '{4'hF, 4'hF, 1'b0, 4'hF, 4'hF, 1'b0, 2'd2, 1'b1, 2'd1, 1'b0, 1'b1};
        tbl[6]  = '{4'h7, 4'hF, 1'b0, 4'h8, 4'h7, 1'b1, 2'd3, 1'b1, 2'd1, 1'b1, 1'b0};
        tbl[7]  = '{4'hF, 4'hF, 1'b0, 4'h0, 4'hF, 1'b0, 2'd3, 1'b1, 2'd1, 1'b0, 1'b1};
        tbl[8]  = '{4'hD, 4'hF, 1'b0, 4'h2, 4'hD, 1'b1, 2'd1, 1'b1, 2'd1, 1'b1, 1'b0};
        tbl[9]  = '{4'h5, 4'hF, 1'b0, 4'h2, 4'hD, 1'b1, 2'd1, 1'b1, 2'd2, 1'b1, 1'b0};
        tbl[10] = '{4'hD, 4'hF, 1'b0, 4'h0, 4'hD, 1'b1, 2'd1, 1'b1, 2'd2, 1'b0, 1'b0};
        tbl[11] = '{4'h5, 4'hF, 1'b0, 4'h0, 4'hD, 1'b1, 2'd1, 1'b1, 2'd3, 1'b0, 1'b0};
        tbl[12] = '{4'hD, 4'hF, 1'b1, 4'h0, 4'hD, 1'b1, 2'd1, 1'b0, 2'd0, 1'b0, 1'b0};
        tbl[13] = '{4'hD, 4'hF, 1'b0, 4'h2, 4'hD, 1'b1, 2'd1, 1'b0, 2'd0, 1'b1, 1'b0};
        tbl[14] = '{4'h5, 4'hF, 1'b0, 4'h2, 4'hD, 1'b1, 2'd1, 1'b1, 2'd1, 1'b1, 1'b0};
        tbl[15] = '{4'hD, 4'hD, 1'b0, 4'h2, 4'hF, 1'b0, 2'd1, 1'b1, 2'd1, 1'b0, 1'b1};
        tbl[16] = '{4'hC, 4'hD, 1'b0, 4'hF, 4'hF, 1'b0, 2'd1, 1'b1, 2'd1, 1'b0, 1'b1};
        tbl[17] = '{4'hE, 4'hD, 1'b0, 4'h1, 4'hE, 1'b1, 2'd0, 1'b1, 2'd1, 1'b1, 1'b0};
        tbl[18] = '{4'hF, 4'hF, 1'b0, 4'h0, 4'hF, 1'b0, 2'd0, 1'b1, 2'd1, 1'b0, 1'b1};

        rst_n = 1'b0; sck = 1'b0; pico = 1'b0;
        drive(4'hF, 4'hF, 1'b0, 4'hF);
        cycles(3);
        check("reset cs", ch_cs, 4'hF);
        check("reset busy", busy, 1'b0);
        check("reset oeb", poci_oeb, 1'b1);
        check("reset poci", poci_o, 1'b0);
        check("reset act", act, 2'd0);
        check("reset conf/cnt", {conf, cnt}, 3'b000);
        check("reset sck/pico", {ch_sck, ch_pico}, 2'b00);
        rst_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].cs, tbl[i].en, tbl[i].clr, tbl[i].poci);
            cycles(6);
            check($sformatf("vec%0d cs", i), ch_cs, tbl[i].e_cs);
            check($sformatf("vec%0d busy", i), busy, tbl[i].e_busy);
            check($sformatf("vec%0d act", i), act, tbl[i].e_act);
            check($sformatf("vec%0d conf", i), conf, tbl[i].e_conf);
            check($sformatf("vec%0d cnt", i), cnt, tbl[i].e_cnt);
            check($sformatf("vec%0d poci", i), {poci_o, poci_oeb}, {tbl[i].e_poci, tbl[i].e_oeb});
            $display("vec %0d: cs_n=%h en=%h -> ch_cs=%h busy=%0d act=%0d conf=%0d cnt=%0d",
                     i, tbl[i].cs, tbl[i].en, ch_cs, busy, act, conf, cnt);
        end

        // Grant and SCK/PICO latency: visible after the third edge, not the second.
        cs = 4'hB; sck = 1'b1; pico = 1'b1;
        cycles(2);
        check("grant early", {ch_cs, ch_sck, ch_pico}, {4'hF, 2'b00});
        cycles(1);
        check("grant cs", ch_cs, 4'hB);
        check("grant busy/act", {busy, act}, {1'b1, 2'd2});
        check("sck/pico delay", {ch_sck, ch_pico}, 2'b11);
        sck = 1'b0; pico = 1'b0;
        cycles(3);
        check("sck/pico fall", {ch_sck, ch_pico}, 2'b00);
        cs = 4'hF;
        cycles(2);
        check("release early", ch_cs, 4'hB);
        cycles(1);
        check("release", {ch_cs, busy, poci_oeb, poci_o}, {4'hF, 1'b1, 1'b1, 1'b0} & 7'b1111_011 | 7'b0000_010);
        $display("latency: grant/release seen after 3 edges");

        // Conflict event in the same cycle as clear: event wins with count 1.
        cs = 4'hD; cycles(6);
        cs = 4'h5; cycles(4);
        cs = 4'hD; cycles(4);
        check("pre-collision cnt", {conf, cnt}, {1'b1, 2'd2});
        cs = 4'h5;
        cycles(2);
        clr = 1'b1;
        cycles(1);
        clr = 1'b0;
        check("collision cnt", {conf, cnt}, {1'b1, 2'd1});
        cycles(1);
        check("collision hold", {conf, cnt, ch_cs}, {1'b1, 2'd1, 4'hD});
        $display("collision: conf=%0d cnt=%0d", conf, cnt);
        cs = 4'hD; cycles(4);

        // Clear, then saturation after five conflicts while ch1 keeps the grant.
        clr = 1'b1; cycles(1); clr = 1'b0;
        check("clear", {conf, cnt}, 3'b000);
        for (int k = 0; k < 5; k++) begin
            cs = 4'h5; cycles(4);
            cs = 4'hD; cycles(4);
        end
        check("saturate", {conf, cnt}, {1'b1, 2'd3});
        check("lock kept", {ch_cs, busy, act}, {4'hD, 1'b1, 2'd1});
        $display("saturation: cnt=%0d after 5 conflicts", cnt);

        // Asynchronous reset mid-transfer.
        poci = 4'hF;
        cycles(1);
        check("poci active", {poci_o, poci_oeb}, 2'b10);
        #2 rst_n = 1'b0;
        #1;
        check("async cs", ch_cs, 4'hF);
        check("async busy/oeb/poci", {busy, poci_oeb, poci_o}, 3'b010);
        check("async act/conf/cnt", {act, conf, cnt}, 5'b0);
        cycles(2);
        rst_n = 1'b1;
        cycles(4);
        check("regrant after reset", {ch_cs, busy, act}, {4'hD, 1'b1, 2'd1});
        $display("reset: cs released asynchronously, ch1 regranted");

        // Random traffic against the reference model.
        rst_n = 1'b0;
        drive(4'hF, 4'hF, 1'b0, 4'h0);
        sck = 1'b0; pico = 1'b0;
        cycles(2);
        model_reset();
        rst_n = 1'b1;
        r_cs = 4'hF; r_en = 4'hF;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(15) == 0) r_cs[b] = ~r_cs[b];
                if ($urandom_range(63) == 0) r_en[b] = ~r_en[b];
            end
            drive(r_cs, r_en, ($urandom_range(31) == 0), 4'($urandom));
            sck  = 1'($urandom);
            pico = 1'($urandom);
            @(posedge clk);
            model_step();
            @(negedge clk);
            exp_v = {m_busy ? ~(4'b1 << m_owner) : 4'hF, m_busy, 2'(m_owner), m_conf, 2'(m_cnt),
                     m_busy ? poci[m_owner] : 1'b0, ~m_busy, m_q_sck[0], m_q_pico[0]};
            got_v = {ch_cs, busy, act, conf, cnt, poci_o, poci_oeb, ch_sck, ch_pico};
            check($sformatf("random cycle %0d", c), got_v, exp_v);
        end
        $display("random: 3000 cycles compared against model");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
